// File: rtl/coe_cfg_pkg.sv
// Shared definitions for the coefficient update sequencer: config word
// field positions, slot addresses, fixed ARM/CLEAR words and FSM states.
package coe_cfg_pkg;

    localparam logic [2:0] SLOT0    = 3'd0;
    localparam logic [2:0] SLOT1    = 3'd1;
    localparam logic [2:0] SLOT2    = 3'd2;
    localparam logic [2:0] SLOT3    = 3'd3;
    localparam logic [2:0] SLOT_ARM = 3'd4;

    localparam int REAL_LSB = 13;
    localparam int IMAG_LSB = 3;
    localparam int ADDR_LSB = 0;
    localparam int LOAD_BIT = 3;
    localparam int VMM_BIT  = 4;

    localparam logic [22:0] WORD_ARM     = 23'h00000C;
    localparam logic [22:0] WORD_ARM_VMM = 23'h00001C;
    localparam logic [22:0] WORD_CLEAR   = 23'h000004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ARM,
        ST_HOLD,
        ST_CLEAR,
        ST_DONE
    } state_t;

    // Build the write word for coefficient slot s.
    function automatic logic [22:0] slot_word(
        input logic [39:0] re,
        input logic [39:0] im,
        input logic [1:0]  s
    );
        logic [22:0] w;
        w = '0;
        w[REAL_LSB +: 10] = re[10*int'(s) +: 10];
        w[IMAG_LSB +: 10] = im[10*int'(s) +: 10];
        w[ADDR_LSB +: 3]  = {1'b0, s};
        return w;
    endfunction

endpackage

// File: rtl/coe_update_sequencer_if.sv
// Request bus into the sequencer: valid/ready handshake, slot mask,
// vmm flag and four packed complex 10-bit coefficients.
interface coe_update_sequencer_if;
    import coe_cfg_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_mask;
    logic        req_vmm;
    logic [39:0] coe_real;
    logic [39:0] coe_imag;

    modport master (
        output req_valid, req_mask, req_vmm, coe_real, coe_imag,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_mask, req_vmm, coe_real, coe_imag,
        output req_ready
    );

endinterface

// File: rtl/coe_mask_scan.sv
// Lowest-set-bit finder over the remaining slot mask.
// i_mask: slots still to write; o_slot: lowest set index; o_any: mask!=0.
module coe_mask_scan
    import coe_cfg_pkg::*;
(
    input  logic [3:0] i_mask,
    output logic [1:0] o_slot,
    output logic       o_any
);

    always_comb begin
        o_any  = |i_mask;
        o_slot = 2'd0;
        // Descending walk so the lowest set bit wins.
        for (int i = 3; i >= 0; i--) begin
            if (i_mask[i]) o_slot = 2'(i);
        end
    end

endmodule

// File: rtl/coe_update_sequencer.sv
// Issues one atomic coefficient update to the config slave: slot writes,
// ARM (load bit), LOAD_HOLD idle cycles, CLEAR, then a done pulse.
// Ports: CLK, rst (async high), req (request bus, slave side),
// ssb/sdi (registered config strobe/word), busy, done.
module coe_update_sequencer
    import coe_cfg_pkg::*;
#(
    parameter int LOAD_HOLD = 2
) (
    input  logic                         CLK,
    input  logic                         rst,
    coe_update_sequencer_if.slave        req,
    output logic                         ssb,
    output logic [22:0]                  sdi,
    output logic                         busy,
    output logic                         done
);

    localparam logic [3:0] HOLD_INIT = 4'(LOAD_HOLD - 1);

    state_t      r_state;
    logic [3:0]  r_mask;
    logic [3:0]  r_cnt;
    logic        r_vmm;
    logic [39:0] r_real;
    logic [39:0] r_imag;
    logic        r_ssb;
    logic [22:0] r_sdi;
    logic        r_done;

    state_t      w_state_n;
    logic [3:0]  w_mask_n;
    logic [3:0]  w_cnt_n;
    logic        w_ssb_n;
    logic [22:0] w_sdi_n;
    logic        w_done_n;
    logic        w_idle;
    logic        w_accept;
    logic [3:0]  w_scan_mask;
    logic [3:0]  w_bit;
    logic [1:0]  w_slot;
    logic        w_any;
    logic [39:0] w_re;
    logic [39:0] w_im;
    logic        w_vmm;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = req.req_valid & w_idle;

    // The first word goes out on the accept edge, so in IDLE the
    // live request is used before it has been latched.
    assign w_scan_mask = w_idle ? req.req_mask : r_mask;
    assign w_re        = w_idle ? req.coe_real : r_real;
    assign w_im        = w_idle ? req.coe_imag : r_imag;
    assign w_vmm       = w_idle ? req.req_vmm  : r_vmm;
    assign w_bit       = 4'b0001 << w_slot;

    coe_mask_scan u_scan (
        .i_mask (w_scan_mask),
        .o_slot (w_slot),
        .o_any  (w_any)
    );

    always_comb begin
        w_state_n = r_state;
        w_mask_n  = r_mask;
        w_cnt_n   = r_cnt;
        w_ssb_n   = 1'b0;
        w_sdi_n   = '0;
        w_done_n  = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_WRITE: begin
                if (w_accept || !w_idle) begin
                    if (w_any) begin
                        w_state_n = ST_WRITE;
                        w_ssb_n   = 1'b1;
                        w_sdi_n   = slot_word(w_re, w_im, w_slot);
                        w_mask_n  = w_scan_mask & ~w_bit;
                    end else begin
                        w_state_n = ST_ARM;
                        w_ssb_n   = 1'b1;
                        w_sdi_n   = w_vmm ? WORD_ARM_VMM : WORD_ARM;
                    end
                end
            end
            ST_ARM: begin
                w_state_n = ST_HOLD;
                w_cnt_n   = HOLD_INIT;
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_n = ST_CLEAR;
                    w_ssb_n   = 1'b1;
                    w_sdi_n   = WORD_CLEAR;
                end else begin
                    w_cnt_n = r_cnt - 4'd1;
                end
            end
            ST_CLEAR: begin
                w_state_n = ST_DONE;
                w_done_n  = 1'b1;
            end
            ST_DONE: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_ssb   <= 1'b0;
            r_sdi   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_mask  <= w_mask_n;
            r_cnt   <= w_cnt_n;
            r_ssb   <= w_ssb_n;
            r_sdi   <= w_sdi_n;
            r_done  <= w_done_n;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_vmm  <= 1'b0;
            r_real <= '0;
            r_imag <= '0;
        end else if (w_accept) begin
            r_vmm  <= req.req_vmm;
            r_real <= req.coe_real;
            r_imag <= req.coe_imag;
        end
    end

    assign ssb           = r_ssb;
    assign sdi           = r_sdi;
    assign done          = r_done;
    assign busy          = !w_idle && (r_state != ST_DONE);
    assign req.req_ready = w_idle;

endmodule

// File: tb/tb_coe_update_sequencer.sv
// Directed bench for coe_update_sequencer (LOAD_HOLD 2, 1 and 15).
// Expected config words are hand-derived from the field layout.
module tb_coe_update_sequencer;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    coe_update_sequencer_if ifa ();
    coe_update_sequencer_if ifb ();
    coe_update_sequencer_if ifc ();

    logic        ssb_a, ssb_b, ssb_c;
    logic [22:0] sdi_a, sdi_b, sdi_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    int errs   = 0;
    int checks = 0;

    logic [23:0] exp_q[$];

    always #5 CLK = ~CLK;

    coe_update_sequencer #(.LOAD_HOLD(2)) dut_a (
        .CLK (CLK), .rst (rst), .req (ifa.slave),
        .ssb (ssb_a), .sdi (sdi_a), .busy (busy_a), .done (done_a)
    );

    coe_update_sequencer #(.LOAD_HOLD(1)) dut_b (
        .CLK (CLK), .rst (rst), .req (ifb.slave),
        .ssb (ssb_b), .sdi (sdi_b), .busy (busy_b), .done (done_b)
    );

    coe_update_sequencer #(.LOAD_HOLD(15)) dut_c (
        .CLK (CLK), .rst (rst), .req (ifc.slave),
        .ssb (ssb_c), .sdi (sdi_c), .busy (busy_c), .done (done_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called one cycle after the accept edge; walks exp_q, then
    // checks the done pulse and the return to IDLE.
    task automatic seq_check(input string tag);
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("%s_k%0d", tag, k + 1), {ssb_a, sdi_a}, exp_q[k]);
            chk($sformatf("%s_busy%0d", tag, k + 1), busy_a, 1'b1);
            tick();
        end
        chk({tag, "_done"}, done_a, 1'b1);
        chk({tag, "_done_busy"}, busy_a, 1'b0);
        chk({tag, "_done_rdy"}, ifa.req_ready, 1'b0);
        chk({tag, "_done_ssb"}, ssb_a, 1'b0);
        tick();
        chk({tag, "_post_done"}, done_a, 1'b0);
        chk({tag, "_post_rdy"}, ifa.req_ready, 1'b1);
    endtask

    task automatic drive_a(input logic [3:0] m, input logic v,
                           input logic [39:0] re, input logic [39:0] im);
        ifa.req_mask = m;
        ifa.req_vmm  = v;
        ifa.coe_real = re;
        ifa.coe_imag = im;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cb, cc;
        logic [22:0] wb, wc;

        ifa.req_valid = 0; ifb.req_valid = 0; ifc.req_valid = 0;
        drive_a(4'h0, 1'b0, '0, '0);
        ifb.req_mask = 0; ifb.req_vmm = 0; ifb.coe_real = 0; ifb.coe_imag = 0;
        ifc.req_mask = 0; ifc.req_vmm = 0; ifc.coe_real = 0; ifc.coe_imag = 0;

        #12;
        chk("rst_ssb", ssb_a, 1'b0);
        chk("rst_sdi", sdi_a, 23'h0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_rdy", ifa.req_ready, 1'b1);
        @(negedge CLK);
        rst = 0;
        tick();

        // Full update, mask F.
        ifa.req_valid = 1;
        drive_a(4'hF, 1'b0, {10'h103, 10'h102, 10'h101, 10'h100},
                {10'h203, 10'h202, 10'h201, 10'h200});
        tick();
        ifa.req_valid = 0;
        chk("full_rdy", ifa.req_ready, 1'b0);
        exp_q = '{24'hA01000, 24'hA03009, 24'hA05012, 24'hA0701B,
                  24'h80000C, 24'h000000, 24'h000000, 24'h800004};
        seq_check("full");

        // Sparse 1010 with vmm; inputs scrambled after accept.
        ifa.req_valid = 1;
        drive_a(4'b1010, 1'b1, {10'h3FF, 10'h155, 10'h2AA, 10'h001},
                {10'h000, 10'h333, 10'h0F0, 10'h123});
        tick();
        ifa.req_valid = 0;
        drive_a(4'hF, 1'b0, '0, '0);
        exp_q = '{24'hD54781, 24'hFFE003, 24'h80001C,
                  24'h000000, 24'h000000, 24'h800004};
        seq_check("sparse");

        // Empty mask: ARM straight away.
        ifa.req_valid = 1;
        drive_a(4'h0, 1'b0, '0, '0);
        tick();
        ifa.req_valid = 0;
        exp_q = '{24'h80000C, 24'h000000, 24'h000000, 24'h800004};
        seq_check("mask0");

        // Valid held high; payload changes while busy.
        ifa.req_valid = 1;
        drive_a(4'b0001, 1'b0, {30'h0, 10'h0AB}, {30'h0, 10'h0CD});
        tick();
        drive_a(4'b0100, 1'b1, {10'h0, 10'h111, 20'h0},
                {10'h0, 10'h222, 20'h0});
        exp_q = '{24'h956668, 24'h80000C, 24'h000000,
                  24'h000000, 24'h800004};
        seq_check("hold_a");
        tick();
        ifa.req_valid = 0;
        chk("hold_b_k1", {ssb_a, sdi_a}, 24'hA23112);
        chk("hold_b_busy", busy_a, 1'b1);
        tick();
        exp_q = '{24'h80001C, 24'h000000, 24'h000000, 24'h800004};
        seq_check("hold_b");

        // Reset asserted during HOLD.
        ifa.req_valid = 1;
        drive_a(4'h0, 1'b0, '0, '0);
        tick();
        ifa.req_valid = 0;
        chk("mid_arm", {ssb_a, sdi_a}, 24'h80000C);
        tick();
        rst = 1;
        #1;
        chk("mid_ssb", ssb_a, 1'b0);
        chk("mid_sdi", sdi_a, 23'h0);
        chk("mid_busy", busy_a, 1'b0);
        chk("mid_done", done_a, 1'b0);
        chk("mid_rdy", ifa.req_ready, 1'b1);
        @(negedge CLK);
        rst = 0;
        tick();
        chk("after_rst_rdy", ifa.req_ready, 1'b1);
        ifa.req_valid = 1;
        drive_a(4'b1000, 1'b0, {10'h3FF, 30'h0}, {10'h000, 30'h0});
        tick();
        ifa.req_valid = 0;
        exp_q = '{24'hFFE003, 24'h80000C, 24'h000000,
                  24'h000000, 24'h800004};
        seq_check("fresh");

        // LOAD_HOLD 1 and 15: gap between ARM and CLEAR strobes.
        ifb.req_valid = 1;
        ifc.req_valid = 1;
        tick();
        ifb.req_valid = 0;
        ifc.req_valid = 0;
        chk("h1_arm", {ssb_b, sdi_b}, 24'h80000C);
        chk("h15_arm", {ssb_c, sdi_c}, 24'h80000C);
        cb = 0; cc = 0; wb = '0; wc = '0;
        for (int k = 2; k < 40; k++) begin
            tick();
            if (ssb_b && cb == 0) begin cb = k; wb = sdi_b; end
            if (ssb_c && cc == 0) begin cc = k; wc = sdi_c; end
        end
        chk("h1_gap", cb - 2, 1);
        chk("h15_gap", cc - 2, 15);
        chk("h1_clear", wb, 23'h000004);
        chk("h15_clear", wc, 23'h000004);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
